// File: rtl/reflet_bus_bridge.sv
// Bridges the Reflet CPU system bus to a request/acknowledge memory port.
// The CPU is stalled through cpu_enable while each access runs.
module reflet_bus_bridge #(
   parameter int wordsize = 16,
   parameter int timeout  = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sys_enable,
   input  logic [wordsize-1:0] cpu_addr,
   input  logic [wordsize-1:0] cpu_data_out,
   input  logic                cpu_write_en,
   output logic [wordsize-1:0] cpu_data_in,
   output logic                cpu_enable,
   output logic                mem_req,
   output logic [wordsize-1:0] mem_addr,
   output logic [wordsize-1:0] mem_wdata,
   output logic                mem_we,
   input  logic                mem_ack,
   input  logic [wordsize-1:0] mem_rdata,
   output logic                bus_error
);

   localparam int CW = $clog2(timeout + 1);
   localparam logic [CW-1:0] LAST = CW'(timeout - 1);

   typedef enum logic [1:0] {CAPTURE, WAIT, PRESENT} state_t;

   state_t        state, next;
   logic [CW-1:0] cnt;
   logic          last;

   assign last = (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= CAPTURE;
      else       state <= next;
   end

   always_comb begin
      next       = state;
      cpu_enable = 1'b0;
      case (state)
         CAPTURE: next = WAIT;
         WAIT:    if (mem_ack || last) next = PRESENT;
         PRESENT: begin
            cpu_enable = sys_enable;
            if (sys_enable) next = CAPTURE;
         end
         default: next = CAPTURE;
      endcase
   end

   // Ack takes priority over the timeout abort when both land on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         cpu_data_in <= '0;
         bus_error   <= 1'b0;
         cnt         <= '0;
      end else begin
         bus_error <= 1'b0;
         case (state)
            CAPTURE: begin
               mem_addr  <= cpu_addr;
               mem_wdata <= cpu_data_out;
               mem_we    <= cpu_write_en;
               mem_req   <= 1'b1;
               cnt       <= '0;
            end
            WAIT: begin
               if (mem_ack) begin
                  mem_req     <= 1'b0;
                  cpu_data_in <= mem_we ? '0 : mem_rdata;
               end else if (last) begin
                  mem_req     <= 1'b0;
                  cpu_data_in <= '1;
                  bus_error   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reflet_bus_bridge.sv
// Directed bench for reflet_bus_bridge: a scoreboard queue holds the expected
// completion {data, bus_error} of each access until the bridge presents it.
module tb_reflet_bus_bridge;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        reset, sys_enable, cpu_write_en, mem_ack;
   logic [15:0] cpu_addr, cpu_data_out, mem_rdata;
   logic [15:0] cpu_data_in, mem_addr, mem_wdata;
   logic        cpu_enable, mem_req, mem_we, bus_error;

   int vectors = 0;
   int errs    = 0;
   logic [16:0] sb[$];

   reflet_bus_bridge #(.wordsize(16), .timeout(TMO)) dut (
      .clk(clk), .reset(reset), .sys_enable(sys_enable),
      .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out), .cpu_write_en(cpu_write_en),
      .cpu_data_in(cpu_data_in), .cpu_enable(cpu_enable),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one access starting in CAPTURE; ack arrives on WAIT cycle d (0-based).
   // With sen=0 the CPU side keeps sys_enable low and PRESENT is held for h cycles.
   task automatic access(input logic [15:0] a, input logic [15:0] wd, input logic we,
                         input logic [15:0] rd, input int d, input logic sen, input int h);
      int n;
      logic [16:0] e;
      cpu_addr = a; cpu_data_out = wd; cpu_write_en = we; mem_rdata = rd;
      sys_enable = sen; mem_ack = (d == 0);
      if (d < TMO) sb.push_back({(we ? 16'h0000 : rd), 1'b0});
      else         sb.push_back({16'hFFFF, 1'b1});
      chk("capture_en", cpu_enable, 0);
      step();
      chk("req_up", mem_req, 1);
      chk("addr", mem_addr, a);
      chk("wdata", mem_wdata, wd);
      chk("we", mem_we, we);
      n = 0;
      while (mem_req === 1'b1 && n < 300) begin
         mem_ack = (n == d);
         cpu_addr = ~a; cpu_data_out = ~wd; cpu_write_en = ~we;
         step();
         n++;
         if (mem_req === 1'b1) begin
            chk("addr_hold", mem_addr, a);
            chk("wdata_hold", mem_wdata, wd);
            chk("we_hold", mem_we, we);
            chk("wait_en", cpu_enable, 0);
         end
      end
      mem_ack = 1'b0;
      chk("req_cycles", n, (d < TMO) ? d + 1 : TMO);
      chk("sb_nonempty", sb.size(), 1);
      e = (sb.size() != 0) ? sb.pop_front() : 17'h0;
      chk("data", cpu_data_in, e[16:1]);
      chk("bus_error", bus_error, e[0]);
      chk("present_en", cpu_enable, sen);
      if (!sen) begin
         mem_ack = 1'b1; mem_rdata = ~rd;
         repeat (h) begin
            step();
            chk("stall_en", cpu_enable, 0);
            chk("stall_data", cpu_data_in, e[16:1]);
            chk("stall_req", mem_req, 0);
            chk("stall_err", bus_error, 0);
         end
         mem_ack = 1'b0;
         sys_enable = 1'b1;
         #1;
         chk("release_en", cpu_enable, 1);
      end
      step();
      chk("err_clear", bus_error, 0);
      chk("capture_en2", cpu_enable, 0);
      chk("capture_req", mem_req, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"}, mem_req, 0);
      chk({tag, "_we"}, mem_we, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_data"}, cpu_data_in, 0);
      chk({tag, "_err"}, bus_error, 0);
      chk({tag, "_en"}, cpu_enable, 0);
   endtask

   initial begin
      reset = 1'b1; sys_enable = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      cpu_addr = 16'h1111; cpu_data_out = 16'h2222; cpu_write_en = 1'b1;
      step(); step();
      chk_reset_vals("rst");
      reset = 1'b0;
      mem_ack = 1'b0;

      access(16'h0010, 16'h0000, 1'b0, 16'hBEEF, 0, 1'b1, 0);   // zero-wait read
      access(16'h0020, 16'h1234, 1'b1, 16'hCAFE, 3, 1'b1, 0);   // wait-state write
      access(16'h0030, 16'h0000, 1'b0, 16'h7777, 1000, 1'b1, 0); // timeout abort
      access(16'h0040, 16'h0000, 1'b0, 16'hA5A5, TMO - 1, 1'b1, 0); // ack on last cycle
      access(16'h0050, 16'h0000, 1'b0, 16'h5555, 2, 1'b0, 5);   // PRESENT stall
      access(16'h0060, 16'h9999, 1'b1, 16'h3333, 1000, 1'b0, 2); // write timeout + stall

      // reset in the middle of WAIT
      cpu_addr = 16'h0070; cpu_data_out = 16'h4444; cpu_write_en = 1'b1; mem_ack = 1'b0;
      step();
      chk("pre_rst_req", mem_req, 1);
      step(); step();
      #2 reset = 1'b1;
      #1 chk_reset_vals("mid");
      step();
      chk_reset_vals("hold");
      reset = 1'b0;
      access(16'h0080, 16'h0000, 1'b0, 16'h0F0F, 1, 1'b1, 0);

      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/reflet_bus_bridge.md
REFLET_BUS_BRIDGE -- requirements
Module: reflet_bus_bridge

Interface
REQ-001 Parameter wordsize, default 16, width of the CPU and memory address and data buses.
REQ-002 Parameter timeout, default 255, maximum WAIT cycles before an access is aborted; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sys_enable  input  1  global run enable from the system.
REQ-006 cpu_addr  input  wordsize  CPU system-bus address.
REQ-007 cpu_data_out  input  wordsize  CPU write data.
REQ-008 cpu_write_en  input  1  CPU write strobe.
REQ-009 cpu_data_in  output  wordsize  read data returned to the CPU.
REQ-010 cpu_enable  output  1  drives the CPU enable pin; CPU advances only when high.
REQ-011 mem_req  output  1  memory request, held until acknowledged or timed out.
REQ-012 mem_addr, mem_wdata  output  wordsize each  latched address and write data.
REQ-013 mem_we  output  1  latched write strobe.
REQ-014 mem_ack  input  1  memory completion; sampled only while mem_req is high.
REQ-015 mem_rdata  input  wordsize  read data, valid in the cycle mem_ack is high.
REQ-016 bus_error  output  1  one-cycle pulse on timeout abort.

Function
REQ-017 FSM states CAPTURE, WAIT, PRESENT; all outputs registered except cpu_enable.
REQ-018 CAPTURE: cpu_enable=0; on the next edge, latch cpu_addr/cpu_data_out/cpu_write_en into mem_addr/mem_wdata/mem_we, set mem_req=1, clear the timeout counter, go WAIT.
REQ-019 WAIT: cpu_enable=0, mem_req=1, mem_addr/mem_wdata/mem_we unchanged; the counter increments every cycle.
REQ-020 WAIT with mem_ack=1 at an edge: mem_req<=0; for reads, cpu_data_in<=mem_rdata; for writes, cpu_data_in<=0; go PRESENT.
REQ-021 WAIT with counter==timeout-1 and mem_ack=0: mem_req<=0, cpu_data_in<=all ones, bus_error<=1 for exactly one cycle, go PRESENT.
REQ-022 mem_ack and timeout in the same cycle: ack wins, no bus_error.
REQ-023 PRESENT: cpu_enable=sys_enable combinationally; cpu_data_in held.
REQ-024 PRESENT exit: go CAPTURE at the first edge with sys_enable=1; stay in PRESENT while sys_enable=0.
REQ-025 mem_ack while mem_req=0 is ignored.
REQ-026 Latency: with mem_ack tied high, one CPU step takes 3 cycles (CAPTURE, WAIT, PRESENT); each memory wait cycle adds one.
REQ-027 sys_enable=0 in CAPTURE or WAIT does not stall the access; only PRESENT waits on it.
REQ-028 The timeout counter is ceil(log2(timeout+1)) bits and never wraps; it saturates at timeout-1.

Reset
REQ-029 While reset=1: state=CAPTURE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_data_in=0, bus_error=0, counter=0, cpu_enable=0.
REQ-030 Reset asserted mid-WAIT drops mem_req immediately (asynchronous) and abandons the access; no completion is reported.
REQ-031 After reset deasserts, the first access starts from CAPTURE at the next edge.

Verification
REQ-032 Zero-wait read: mem_ack=1, mem_rdata=16'hBEEF, cpu_addr=16'h0010 -> mem_addr=16'h0010 with mem_req high 1 cycle; cpu_enable high in cycle 3 with cpu_data_in=16'hBEEF.
REQ-033 Wait-state write: cpu_write_en=1, cpu_data_out=16'h1234, ack after 4 cycles -> mem_we=1 and mem_wdata=16'h1234 stable for 4 cycles; then PRESENT with cpu_data_in=0.
REQ-034 Timeout: timeout=8, mem_ack=0 -> mem_req high 8 cycles, bus_error 1-cycle pulse, cpu_data_in=16'hFFFF, cpu_enable high in the next cycle.
REQ-035 Ack at the last timeout cycle -> read data is returned and bus_error stays 0.
REQ-036 sys_enable=0 during PRESENT for 5 cycles -> cpu_enable=0 and cpu_data_in held; the next CAPTURE starts only after sys_enable=1.
REQ-037 Reset pulse during WAIT -> mem_req=0 in the same cycle and all outputs return to their REQ-029 values.
